rc_f2c_responder: RTL and testbench
===================================

// Module: rc_f2c_responder
// PURPOSE
//  Fabric-to-core responder at the target end of the ring protocol. Accepts RD/WR/WR_BCAST requests
//  from the local ring controller addressed to this core, buffers them in F2C_ENTRIESNUM entries,
//  issues them to local memory/CR and returns RD_RSP packets to the ring output mux (F2C_RESPONSE winner).
// PARAMETERS
//  F2C_ENTRIESNUM  4   number of request buffer entries (F2C_MSB/F2C_ENC_MSB derived as in lotr_pkg)
//  MEM_LAT_MAX     8   max cycles F2cMemRspValid may lag an issued read; exceeding it sets ErrSticky
// PORTS
//  QClk              in   1   clock; single clock domain
//  RstQnnnL          in   1   asynchronous, active-low reset
//  CoreId            in   8   this core's agent id (compared with address [31:24])
//  RingReqValid      in   1   ring request present this cycle
//  RingReqOpcode     in   2   t_opcode
//  RingReqAddress    in   32  agent_id[31:24] | region[23:22] | offset
//  RingReqData       in   32  write data
//  RingReqRequestor  in   8   originating core id
//  RingReqStall      out  1   request targets this core but buffer full; ring controller re-circulates it
//  F2cMemReqValid    out  1   memory/CR access valid
//  F2cMemReqReady    in   1   memory accepts access this cycle
//  F2cMemReqWrEn     out  1   1=write, 0=read
//  F2cMemReqAddress  out  32  access address (unchanged from ring)
//  F2cMemReqData     out  32  write data
//  F2cMemRspValid    in   1   read data valid (exactly one per issued read)
//  F2cMemRspData     in   32  read data
//  RspValid          out  1   RD_RSP packet ready for ring output
//  RspGnt            in   1   ring output mux selected F2C_RESPONSE this cycle
//  RspOpcode         out  2   always RD_RSP
//  RspAddress        out  32  original read address, [31:24] replaced by requestor id
//  RspData           out  32  read data
//  ErrSticky         out  1   protocol error seen; cleared only by reset
// BEHAVIOUR
//  - Reset: all entries FREE; every output 0 (RspOpcode 0 until RspValid).
//  - Per-entry t_state: FREE, WRITE, READ, READ_PRGRS, READ_RDY; ERROR never stored (flag instead).
//  - Hit: RingReqValid & opcode!=RD_RSP & (Address[31:24]==CoreId | (opcode==WR_BCAST & Address[31:24]==8'hFF)).
//    Non-hits and RD_RSP are ignored: no allocation, no stall.
//  - Alloc: hit with a free entry -> lowest-index FREE entry written at next edge (WR/WR_BCAST->WRITE,
//    RD->READ). Free vector is from registered state: an entry freed this cycle is not reusable until
//    next cycle. Hit with no free entry -> RingReqStall=1 combinationally, nothing stored.
//  - Issue: one access per cycle; priority = oldest entry (per-entry age counter, ties impossible)
//    among WRITE/READ. READ issue blocked while any entry is READ_PRGRS (one outstanding read; writes
//    may pass it). On F2cMemReqValid&F2cMemReqReady: WRITE->FREE, READ->READ_PRGRS. Outputs held
//    stable while Valid & !Ready.
//  - Read return: F2cMemRspValid captures data into the READ_PRGRS entry -> READ_RDY next edge.
//    F2cMemRspValid with no READ_PRGRS entry, or wait > MEM_LAT_MAX cycles -> ErrSticky=1, data dropped.
//  - Response: RspValid=1 whenever any READ_RDY exists; oldest READ_RDY presented; fields stable until
//    RspGnt. RspGnt & RspValid -> entry FREE next edge. RspGnt while !RspValid ignored.
//  - Latency: request accepted at edge N -> earliest issue cycle N+1; mem response in cycle M ->
//    RspValid in cycle M+1. Minimum RD round trip with zero-wait memory: 3 cycles.
//  - Simultaneous: alloc, issue, read return and response grant may all occur in one cycle on
//    different entries; all take effect. Age order preserved across wrap of entry indices.
//  - Reset mid-operation: in-flight entries discarded; no RspValid/ F2cMemReqValid after reset until
//    new requests arrive.
// TESTING
//  1 RD addr {CoreId=8'h02,D_MEM_REGION,off 0x10}, mem rsp 0xDEADBEEF after 1 cycle, RspGnt on first
//    RspValid -> RspOpcode=RD_RSP, RspData=0xDEADBEEF, RspAddress[31:24]=requestor, entry freed.
//  2 Five back-to-back WR hits with F2cMemReqReady=0 -> 4 accepted, 5th sees RingReqStall=1;
//    Ready=1 -> 4 writes issued in arrival order, then stall drops.
//  3 WR_BCAST with Address[31:24]=8'hFF and WR to another core id -> only broadcast written locally.
//  4 RD then WR to different offsets, read mem latency 5 -> write issues while read in flight;
//    second RD waits until first RD reaches READ_RDY.
//  5 Two READ_RDY entries, RspGnt held low 10 cycles -> RspValid stays 1, fields stable, older first.
//  6 F2cMemRspValid with no outstanding read; then RstQnnnL pulse mid-read -> ErrSticky=1,
//    after reset all outputs 0 and ErrSticky=0.

Source files
------------

// File: rtl/rc_f2c_responder.sv
// Fabric-to-core responder: buffers ring requests addressed to this core, issues them to local
// memory in age order and returns read data to the ring as RD_RSP packets.
module rc_f2c_responder #(
    parameter int unsigned F2C_ENTRIESNUM = 4,
    parameter int unsigned MEM_LAT_MAX    = 8
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    input  logic [7:0]  CoreId,
    input  logic        RingReqValid,
    input  logic [1:0]  RingReqOpcode,
    input  logic [31:0] RingReqAddress,
    input  logic [31:0] RingReqData,
    input  logic [7:0]  RingReqRequestor,
    output logic        RingReqStall,
    output logic        F2cMemReqValid,
    input  logic        F2cMemReqReady,
    output logic        F2cMemReqWrEn,
    output logic [31:0] F2cMemReqAddress,
    output logic [31:0] F2cMemReqData,
    input  logic        F2cMemRspValid,
    input  logic [31:0] F2cMemRspData,
    output logic        RspValid,
    input  logic        RspGnt,
    output logic [1:0]  RspOpcode,
    output logic [31:0] RspAddress,
    output logic [31:0] RspData,
    output logic        ErrSticky
);
    localparam int unsigned F2C_MSB     = F2C_ENTRIESNUM - 1;
    localparam int unsigned F2C_ENC_MSB = $clog2(F2C_ENTRIESNUM) - 1;
    localparam int unsigned LAT_W       = $clog2(MEM_LAT_MAX + 1);

    localparam logic [1:0] OP_RD       = 2'b00;
    localparam logic [1:0] OP_RD_RSP   = 2'b01;
    localparam logic [1:0] OP_WR_BCAST = 2'b11;

    typedef logic [F2C_ENC_MSB:0] idx_t;
    typedef enum logic [2:0] {FREE, WRITE, READ, READ_PRGRS, READ_RDY} t_state;

    t_state            state_q [F2C_ENTRIESNUM];
    t_state            state_d [F2C_ENTRIESNUM];
    logic [31:0]       addr_q  [F2C_ENTRIESNUM];
    logic [31:0]       addr_d  [F2C_ENTRIESNUM];
    logic [31:0]       data_q  [F2C_ENTRIESNUM];
    logic [31:0]       data_d  [F2C_ENTRIESNUM];
    logic [7:0]        reqr_q  [F2C_ENTRIESNUM];
    logic [7:0]        reqr_d  [F2C_ENTRIESNUM];
    idx_t              rank_q  [F2C_ENTRIESNUM];
    idx_t              rank_d  [F2C_ENTRIESNUM];
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              pend_q, pend_d;
    idx_t              pend_idx_q, pend_idx_d;
    logic              err_q, err_d;

    logic              hit, any_free, any_prgrs, iss_found, rsp_found;
    idx_t              free_idx, prgrs_idx, iss_idx, rsp_idx, dec, surv;
    logic [F2C_MSB:0]  freed;

    // Entry selection; rank 0 is the oldest live entry.
    always_comb begin
        hit = RingReqValid && (RingReqOpcode != OP_RD_RSP) &&
              ((RingReqAddress[31:24] == CoreId) ||
               (RingReqOpcode == OP_WR_BCAST && RingReqAddress[31:24] == 8'hFF));
        any_free  = 1'b0;
        free_idx  = '0;
        any_prgrs = 1'b0;
        prgrs_idx = '0;
        for (int i = F2C_ENTRIESNUM - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                any_free = 1'b1;
                free_idx = idx_t'(i);
            end
            if (state_q[i] == READ_PRGRS) begin
                any_prgrs = 1'b1;
                prgrs_idx = idx_t'(i);
            end
        end
        iss_found = 1'b0;
        iss_idx   = '0;
        rsp_found = 1'b0;
        rsp_idx   = '0;
        if (pend_q) begin
            iss_found = 1'b1;
            iss_idx   = pend_idx_q;
        end else begin
            for (int i = 0; i < F2C_ENTRIESNUM; i++) begin
                if ((state_q[i] == WRITE || (state_q[i] == READ && !any_prgrs)) &&
                    (!iss_found || rank_q[i] < rank_q[iss_idx])) begin
                    iss_found = 1'b1;
                    iss_idx   = idx_t'(i);
                end
            end
        end
        for (int i = 0; i < F2C_ENTRIESNUM; i++) begin
            if (state_q[i] == READ_RDY && (!rsp_found || rank_q[i] < rank_q[rsp_idx])) begin
                rsp_found = 1'b1;
                rsp_idx   = idx_t'(i);
            end
        end
    end

    assign RingReqStall     = hit && !any_free;
    assign F2cMemReqValid   = iss_found;
    assign F2cMemReqWrEn    = iss_found && (state_q[iss_idx] == WRITE);
    assign F2cMemReqAddress = iss_found ? addr_q[iss_idx] : 32'h0;
    assign F2cMemReqData    = iss_found ? data_q[iss_idx] : 32'h0;
    assign RspValid         = rsp_found;
    assign RspOpcode        = rsp_found ? OP_RD_RSP : 2'b00;
    assign RspAddress       = rsp_found ? {reqr_q[rsp_idx], addr_q[rsp_idx][23:0]} : 32'h0;
    assign RspData          = rsp_found ? data_q[rsp_idx] : 32'h0;
    assign ErrSticky        = err_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        reqr_d     = reqr_q;
        rank_d     = rank_q;
        lat_d      = lat_q;
        err_d      = err_q;
        freed      = '0;
        dec        = '0;
        surv       = '0;
        // Lock a stalled issue so an older read unblocked meanwhile cannot displace it.
        pend_d     = iss_found && !F2cMemReqReady;
        pend_idx_d = iss_idx;

        if (iss_found && F2cMemReqReady) begin
            if (state_q[iss_idx] == WRITE) begin
                state_d[iss_idx] = FREE;
                freed[iss_idx]   = 1'b1;
            end else begin
                state_d[iss_idx] = READ_PRGRS;
                lat_d            = LAT_W'(1);
            end
        end

        if (any_prgrs) begin
            if (F2cMemRspValid) begin
                state_d[prgrs_idx] = READ_RDY;
                data_d[prgrs_idx]  = F2cMemRspData;
            end else if (lat_q == LAT_W'(MEM_LAT_MAX)) begin
                // Abandon the timed-out read so the buffer cannot deadlock.
                state_d[prgrs_idx] = FREE;
                freed[prgrs_idx]   = 1'b1;
                err_d              = 1'b1;
            end else begin
                lat_d = lat_q + LAT_W'(1);
            end
        end else if (F2cMemRspValid) begin
            err_d = 1'b1;
        end

        if (RspGnt && rsp_found) begin
            state_d[rsp_idx] = FREE;
            freed[rsp_idx]   = 1'b1;
        end

        for (int i = 0; i < F2C_ENTRIESNUM; i++) begin
            if (state_q[i] != FREE && !freed[i]) begin
                dec = '0;
                for (int j = 0; j < F2C_ENTRIESNUM; j++) begin
                    if (freed[j] && rank_q[j] < rank_q[i]) dec = dec + idx_t'(1);
                end
                rank_d[i] = rank_q[i] - dec;
                surv      = surv + idx_t'(1);
            end
        end

        if (hit && any_free) begin
            state_d[free_idx] = (RingReqOpcode == OP_RD) ? READ : WRITE;
            addr_d[free_idx]  = RingReqAddress;
            data_d[free_idx]  = RingReqData;
            reqr_d[free_idx]  = RingReqRequestor;
            rank_d[free_idx]  = surv;
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            for (int i = 0; i < F2C_ENTRIESNUM; i++) begin
                state_q[i] <= FREE;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                reqr_q[i]  <= '0;
                rank_q[i]  <= '0;
            end
            lat_q      <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            reqr_q     <= reqr_d;
            rank_q     <= rank_d;
            lat_q      <= lat_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_rc_f2c_responder.sv
// Bench for rc_f2c_responder: directed scenarios plus random traffic, all checked each cycle
// against an age-ordered queue model of outstanding requests.
module tb_rc_f2c_responder;
    localparam int MEM_LAT_MAX = 8;
    localparam logic [1:0] OP_RD = 2'b00, OP_RD_RSP = 2'b01, OP_WR = 2'b10, OP_WR_BCAST = 2'b11;
    localparam int ST_WR = 1, ST_RD = 2, ST_PRG = 3, ST_RDY = 4;
    localparam logic [7:0] CORE = 8'h02;

    logic QClk = 1'b0, RstQnnnL = 1'b0;
    logic RingReqValid = 0, F2cMemReqReady = 0, F2cMemRspValid = 0, RspGnt = 0;
    logic [1:0] RingReqOpcode = 0;
    logic [31:0] RingReqAddress = 0, RingReqData = 0, F2cMemRspData = 0;
    logic [7:0] RingReqRequestor = 0;
    logic RingReqStall, F2cMemReqValid, F2cMemReqWrEn, RspValid, ErrSticky;
    logic [31:0] F2cMemReqAddress, F2cMemReqData, RspAddress, RspData;
    logic [1:0] RspOpcode;

    rc_f2c_responder #(.F2C_ENTRIESNUM(4), .MEM_LAT_MAX(MEM_LAT_MAX)) dut (
        .QClk(QClk), .RstQnnnL(RstQnnnL), .CoreId(CORE),
        .RingReqValid(RingReqValid), .RingReqOpcode(RingReqOpcode),
        .RingReqAddress(RingReqAddress), .RingReqData(RingReqData),
        .RingReqRequestor(RingReqRequestor), .RingReqStall(RingReqStall),
        .F2cMemReqValid(F2cMemReqValid), .F2cMemReqReady(F2cMemReqReady),
        .F2cMemReqWrEn(F2cMemReqWrEn), .F2cMemReqAddress(F2cMemReqAddress),
        .F2cMemReqData(F2cMemReqData), .F2cMemRspValid(F2cMemRspValid),
        .F2cMemRspData(F2cMemRspData), .RspValid(RspValid), .RspGnt(RspGnt),
        .RspOpcode(RspOpcode), .RspAddress(RspAddress), .RspData(RspData),
        .ErrSticky(ErrSticky)
    );

    always #5 QClk = ~QClk;

    typedef struct {
        int id; bit rd; logic [31:0] addr; logic [31:0] data; logic [7:0] reqr;
        int st; int lat; int tgt;
    } rec_t;

    rec_t mq[$];
    int pend_id = -1, next_id = 0, e_iss = -1, e_rsp = -1;
    bit m_err = 0, e_hit = 0;
    int checks = 0, errors = 0;

    bit rst_v = 0, req_v = 0, ready_v = 0, mrsp_v = 0, gnt_v = 0;
    logic [1:0] opc_v = 0;
    logic [31:0] addr_v = 0, data_v = 0, mrsp_d = 0;
    logic [7:0] reqr_v = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        req_v = 0; ready_v = 0; mrsp_v = 0; gnt_v = 0;
    endtask

    // Drive inputs mid-cycle, then compare every output with the model.
    task automatic settle();
        bit any_pr;
        logic [31:0] ea, ed, ra, rd;
        @(negedge QClk);
        RstQnnnL = rst_v; RingReqValid = req_v; RingReqOpcode = opc_v; RingReqAddress = addr_v;
        RingReqData = data_v; RingReqRequestor = reqr_v; F2cMemReqReady = ready_v;
        F2cMemRspValid = mrsp_v; F2cMemRspData = mrsp_d; RspGnt = gnt_v;
        if (!rst_v) begin
            mq.delete(); pend_id = -1; m_err = 0;
        end
        #1;
        any_pr = 0; e_iss = -1; e_rsp = -1;
        foreach (mq[k]) if (mq[k].st == ST_PRG) any_pr = 1;
        if (pend_id >= 0) begin
            foreach (mq[k]) if (mq[k].id == pend_id) e_iss = k;
        end else begin
            foreach (mq[k])
                if (e_iss < 0 && (mq[k].st == ST_WR || (mq[k].st == ST_RD && !any_pr))) e_iss = k;
        end
        foreach (mq[k]) if (e_rsp < 0 && mq[k].st == ST_RDY) e_rsp = k;
        e_hit = rst_v && req_v && opc_v != OP_RD_RSP &&
                (addr_v[31:24] == CORE || (opc_v == OP_WR_BCAST && addr_v[31:24] == 8'hFF));
        ea = (e_iss >= 0) ? mq[e_iss].addr : 32'h0;
        ed = (e_iss >= 0) ? mq[e_iss].data : 32'h0;
        ra = (e_rsp >= 0) ? {mq[e_rsp].reqr, mq[e_rsp].addr[23:0]} : 32'h0;
        rd = (e_rsp >= 0) ? mq[e_rsp].data : 32'h0;
        chk("stall", RingReqStall, e_hit && mq.size() >= 4);
        chk("mreq_valid", F2cMemReqValid, e_iss >= 0);
        chk("mreq_wren", F2cMemReqWrEn, e_iss >= 0 && mq[e_iss].st == ST_WR);
        chk("mreq_addr", F2cMemReqAddress, ea);
        chk("mreq_data", F2cMemReqData, ed);
        chk("rsp_valid", RspValid, e_rsp >= 0);
        chk("rsp_opcode", RspOpcode, (e_rsp >= 0) ? OP_RD_RSP : 2'b00);
        chk("rsp_addr", RspAddress, ra);
        chk("rsp_data", RspData, rd);
        chk("err_sticky", ErrSticky, m_err);
    endtask

    // Advance the model by one clock using the inputs driven in settle().
    task automatic tick();
        int pr, n0;
        bit rm[$];
        rec_t r;
        if (rst_v) begin
            n0 = mq.size(); pr = -1;
            foreach (mq[k]) begin
                rm.push_back(1'b0);
                if (mq[k].st == ST_PRG) pr = k;
            end
            if (e_iss >= 0 && ready_v) begin
                if (mq[e_iss].st == ST_WR) rm[e_iss] = 1'b1;
                else begin
                    mq[e_iss].st = ST_PRG; mq[e_iss].lat = 1;
                    mq[e_iss].tgt = $urandom_range(1, MEM_LAT_MAX);
                end
                pend_id = -1;
            end else pend_id = (e_iss >= 0) ? mq[e_iss].id : -1;
            if (pr >= 0) begin
                if (mrsp_v) begin
                    mq[pr].st = ST_RDY; mq[pr].data = mrsp_d;
                end else if (mq[pr].lat == MEM_LAT_MAX) begin
                    rm[pr] = 1'b1; m_err = 1;
                end else mq[pr].lat++;
            end else if (mrsp_v) m_err = 1;
            if (gnt_v && e_rsp >= 0) rm[e_rsp] = 1'b1;
            for (int k = n0 - 1; k >= 0; k--) if (rm[k]) mq.delete(k);
            if (e_hit && n0 < 4) begin
                r.id = next_id; r.rd = (opc_v == OP_RD); r.addr = addr_v; r.data = data_v;
                r.reqr = reqr_v; r.st = r.rd ? ST_RD : ST_WR; r.lat = 0; r.tgt = 0;
                next_id++;
                mq.push_back(r);
            end
        end
        @(posedge QClk);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic auto_mem();
        mrsp_v = 0;
        foreach (mq[k]) if (mq[k].st == ST_PRG && mq[k].lat >= mq[k].tgt) begin
            mrsp_v = 1; mrsp_d = $urandom;
        end
    endtask

    task automatic drain();
        int n = 0;
        req_v = 0; ready_v = 1; gnt_v = 1;
        while (mq.size() > 0 && n < 80) begin
            auto_mem(); cycle(); n++;
        end
        if (mq.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d entries expected 0", mq.size());
        end
        idle(); settle();
        chk("drain_mreq_idle", F2cMemReqValid, 0);
        chk("drain_rsp_idle", RspValid, 0);
        tick();
    endtask

    task automatic put_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        req_v = 1; opc_v = op; addr_v = a; data_v = d; reqr_v = 8'h05;
    endtask

    initial begin
        rst_v = 0; idle(); cycle(); cycle();
        rst_v = 1; settle();
        chk("reset_mreq", F2cMemReqValid, 0); chk("reset_rsp", RspValid, 0);
        chk("reset_opcode", RspOpcode, 0); chk("reset_err", ErrSticky, 0);
        tick();

        // Single read, 3-cycle round trip.
        put_req(OP_RD, 32'h02400010, 32'h0); cycle();
        idle(); ready_v = 1; settle();
        chk("t1_issue_valid", F2cMemReqValid, 1); chk("t1_issue_wren", F2cMemReqWrEn, 0);
        chk("t1_issue_addr", F2cMemReqAddress, 32'h02400010); tick();
        idle(); mrsp_v = 1; mrsp_d = 32'hDEADBEEF; cycle();
        idle(); gnt_v = 1; settle();
        chk("t1_rsp_valid", RspValid, 1); chk("t1_rsp_opcode", RspOpcode, 2'b01);
        chk("t1_rsp_data", RspData, 32'hDEADBEEF); chk("t1_rsp_addr", RspAddress, 32'h05400010);
        tick();
        idle(); settle(); chk("t1_freed", RspValid, 0); tick();

        // Five writes into four entries with memory not ready.
        for (int i = 0; i < 5; i++) begin
            put_req(OP_WR, 32'h02000000 + 32'(i * 4), 32'hA0000000 + 32'(i));
            settle(); chk("t2_stall", RingReqStall, i == 4); tick();
        end
        idle(); ready_v = 1;
        for (int i = 0; i < 4; i++) begin
            settle(); chk("t2_order", F2cMemReqData, 32'hA0000000 + 32'(i));
            chk("t2_wren", F2cMemReqWrEn, 1); tick();
        end
        put_req(OP_WR, 32'h02000100, 32'h5); settle(); chk("t2_stall_drop", RingReqStall, 0); tick();
        drain();

        // Broadcast accepted, write to another core ignored.
        put_req(OP_WR_BCAST, 32'hFF000040, 32'h11); cycle();
        put_req(OP_WR, 32'h07000080, 32'h22); cycle();
        idle(); ready_v = 1; settle();
        chk("t3_bcast_valid", F2cMemReqValid, 1); chk("t3_bcast_addr", F2cMemReqAddress, 32'hFF000040);
        tick();
        settle(); chk("t3_other_ignored", F2cMemReqValid, 0); tick();

        // Write passes an in-flight read; second read waits.
        idle(); ready_v = 1;
        put_req(OP_RD, 32'h02000A00, 0); cycle();
        put_req(OP_WR, 32'h02000B00, 32'h33); cycle();
        put_req(OP_RD, 32'h02000C00, 0); cycle();
        req_v = 0;
        for (int k = 3; k <= 6; k++) begin
            mrsp_v = (k == 6); mrsp_d = 32'hCAFE0001; settle();
            if (k == 3) chk("t4_rd_blocked", F2cMemReqValid, 0);
            tick();
        end
        mrsp_v = 0; settle();
        chk("t4_rd2_issue", F2cMemReqValid, 1); chk("t4_rd2_addr", F2cMemReqAddress, 32'h02000C00);
        tick();
        drain();

        // Two ready responses held without grant.
        idle(); ready_v = 1;
        put_req(OP_RD, 32'h02000100, 0); cycle();
        put_req(OP_RD, 32'h02000200, 0); cycle();
        req_v = 0; mrsp_v = 1; mrsp_d = 32'h11110001; cycle();
        mrsp_v = 0; cycle();
        mrsp_v = 1; mrsp_d = 32'h22220002; cycle();
        mrsp_v = 0;
        for (int i = 0; i < 10; i++) begin
            settle(); chk("t5_hold_valid", RspValid, 1); chk("t5_hold_data", RspData, 32'h11110001);
            tick();
        end
        gnt_v = 1; cycle();
        settle(); chk("t5_second", RspData, 32'h22220002); tick();
        drain();

        // Spurious response, then reset in the middle of a read.
        idle(); mrsp_v = 1; mrsp_d = 32'h1; cycle();
        idle(); settle(); chk("t6_spurious_err", ErrSticky, 1); tick();
        ready_v = 1; put_req(OP_RD, 32'h02000300, 0); cycle();
        req_v = 0; cycle(); cycle();
        rst_v = 0; settle();
        chk("t6_rst_err", ErrSticky, 0); chk("t6_rst_mreq", F2cMemReqValid, 0);
        chk("t6_rst_rsp", RspValid, 0); chk("t6_rst_opc", RspOpcode, 0);
        tick();
        rst_v = 1; idle(); settle();
        chk("t6_post_err", ErrSticky, 0); chk("t6_post_rsp", RspValid, 0); tick();

        // Read that never returns times out.
        ready_v = 1; put_req(OP_RD, 32'h02000400, 0); cycle();
        req_v = 0;
        for (int i = 0; i < 12; i++) cycle();
        settle(); chk("t6_timeout_err", ErrSticky, 1); chk("t6_timeout_rsp", RspValid, 0); tick();
        rst_v = 0; idle(); cycle(); rst_v = 1; cycle();

        // Random traffic with a well-behaved memory.
        for (int n = 0; n < 3000; n++) begin
            int sel;
            req_v = ($urandom % 3) != 0;
            opc_v = 2'($urandom);
            sel = $urandom % 4;
            addr_v = $urandom;
            addr_v[31:24] = (sel < 2) ? CORE : (sel == 2) ? 8'hFF : 8'h40 + 8'($urandom % 16);
            data_v = $urandom; reqr_v = 8'($urandom);
            ready_v = ($urandom % 4) != 0;
            gnt_v = ($urandom % 3) == 0;
            auto_mem();
            cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
